// File: rtl/debounce_multi.sv
// debounce_multi
// Multi-channel switch debouncer with press, release and long-press pulses.
// Each channel is synchronised through two flops and then filtered. A new level
// is accepted only after DEBOUNCE_CNT consecutive cycles that disagree with the
// current debounced state. A hold counter then times how long the debounced
// level stays active and raises a long-press pulse once per press.
//
// Ports
//   clk           : the only clock; all state updates on its rising edge
//   reset         : synchronous, active-high
//   switch_in     : raw, asynchronous switch levels (N_CH bits)
//   switch_state  : debounced logical level for each channel
//   press_pulse   : one-cycle pulse on the edge where switch_state rises
//   release_pulse : one-cycle pulse on the edge where switch_state falls
//   long_pulse    : one-cycle pulse once a press has been held HOLD_CNT cycles
//   any_active    : registered OR of switch_state, one cycle behind it
module debounce_multi #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 8,
    parameter int DEBOUNCE_CNT = 200,
    parameter int ACTIVE_LOW   = 1,
    parameter int HOLD_W       = 16,
    parameter int HOLD_CNT     = 20000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] switch_in,
    output logic [N_CH-1:0] switch_state,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic            any_active
);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CNT);

    logic [N_CH-1:0]              sync0_q, sync0_d;
    logic [N_CH-1:0]              sync1_q, sync1_d;
    logic [N_CH-1:0]              state_q, state_d;
    logic [N_CH-1:0]              press_q, press_d;
    logic [N_CH-1:0]              release_q, release_d;
    logic [N_CH-1:0]              long_q, long_d;
    logic [N_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CH-1:0][HOLD_W-1:0]  hold_q, hold_d;
    logic                         any_q, any_d;

    always_comb begin
        // The polarity fix is applied before the first synchroniser flop so
        // everything downstream works in "1 = pressed" terms.
        sync0_d = (ACTIVE_LOW != 0) ? ~switch_in : switch_in;
        sync1_d = sync0_q;
        any_d   = |state_q;

        for (int i = 0; i < N_CH; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = '0;
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            hold_d[i]    = '0;
            long_d[i]    = 1'b0;

            // Any agreeing cycle leaves cnt at 0, so acceptance needs an
            // unbroken run of mismatches. cnt wraps back to 0 on the accepting
            // edge and therefore never passes CNT_LAST.
            if (state_q[i] != sync1_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    state_d[i]   = ~state_q[i];
                    press_d[i]   = ~state_q[i];
                    release_d[i] =  state_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end

            // The hold timer follows the registered state, so it clears on the
            // edge after a release. On the release edge itself it is frozen so
            // that a long pulse cannot coincide with the release pulse.
            if (state_q[i]) begin
                if (release_d[i]) begin
                    hold_d[i] = hold_q[i];
                end else begin
                    hold_d[i] = (hold_q[i] == HOLD_MAX) ? hold_q[i]
                                                        : hold_q[i] + HOLD_W'(1);
                    long_d[i] = (hold_q[i] == HOLD_LAST);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q   <= '0;
            sync1_q   <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            any_q     <= 1'b0;
        end else begin
            sync0_q   <= sync0_d;
            sync1_q   <= sync1_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            any_q     <= any_d;
        end
    end

    assign switch_state  = state_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign any_active    = any_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi (N_CH=4, DEBOUNCE_CNT=4, HOLD_CNT=10).
// Stimulus pushes expected pulse events, stamped with the absolute cycle they
// are due, into a queue. The monitor pops one entry whenever the DUT shows any
// pulse and flags both unexpected pulses and missed events.
module tb_debounce_multi;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] state;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] switch_in;
    logic [3:0] switch_state, press_pulse, release_pulse, long_pulse;
    logic       any_active;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    debounce_multi #(
        .N_CH(4), .CNT_W(8), .DEBOUNCE_CNT(4), .ACTIVE_LOW(1),
        .HOLD_W(16), .HOLD_CNT(10)
    ) dut (
        .clk(clk), .reset(reset), .switch_in(switch_in),
        .switch_state(switch_state), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .long_pulse(long_pulse),
        .any_active(any_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: runs on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missed_event: due cycle %0d, now %0d, want p=%b r=%b l=%b",
                     exp_q[0].cyc, cyc, exp_q[0].press, exp_q[0].rel, exp_q[0].lng);
            void'(exp_q.pop_front());
        end
        if ((press_pulse | release_pulse | long_pulse) != 4'b0) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                errors++;
                $display("FAIL unexpected_pulse: cycle %0d got p=%b r=%b l=%b, want none",
                         cyc, press_pulse, release_pulse, long_pulse);
            end else begin
                if (press_pulse !== exp_q[0].press || release_pulse !== exp_q[0].rel ||
                    long_pulse !== exp_q[0].lng || switch_state !== exp_q[0].state) begin
                    errors++;
                    $display("FAIL pulse_event: cycle %0d got p=%b r=%b l=%b s=%b, want p=%b r=%b l=%b s=%b",
                             cyc, press_pulse, release_pulse, long_pulse, switch_state,
                             exp_q[0].press, exp_q[0].rel, exp_q[0].lng, exp_q[0].state);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] l, input logic [3:0] s);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.state = s;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: cycle %0d got %b, want %b", name, cyc, act, want);
        end
    endtask

    // Wait (bounded) for every queued event to be consumed, then idle briefly.
    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d events still pending", exp_q.size());
            exp_q.delete();
        end
        tick(3);
    endtask

    initial begin
        int k;
        reset     = 1'b1;
        switch_in = 4'hF;
        tick(3);
        chk("reset_state",  switch_state, 4'b0000);
        chk("reset_pulses", press_pulse | release_pulse | long_pulse, 4'b0000);
        chk("reset_any",    {3'b0, any_active}, 4'b0000);

        // Idle-high inputs: leaving reset must be silent.
        reset = 1'b0;
        tick(10);
        chk("idle_state", switch_state, 4'b0000);
        chk("idle_any",   {3'b0, any_active}, 4'b0000);

        // Channel 0 press: accepted 6 edges after the change, long 10 later.
        k = cyc; switch_in[0] = 1'b0;
        push_ev(k + 6,  4'b0001, 4'b0000, 4'b0000, 4'b0001);
        push_ev(k + 16, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        tick(5);
        chk("ch0_before_accept", switch_state, 4'b0000);
        tick(1);
        chk("ch0_accept", switch_state, 4'b0001);
        tick(14);
        k = cyc; switch_in[0] = 1'b1;
        push_ev(k + 6, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        drain();

        // Channel 1 glitch of 3 cycles is filtered out.
        switch_in[1] = 1'b0;
        tick(3);
        switch_in[1] = 1'b1;
        tick(15);
        chk("ch1_glitch_state", switch_state, 4'b0000);

        // Channel 2 held 30 cycles: exactly one long pulse, then release.
        k = cyc; switch_in[2] = 1'b0;
        push_ev(k + 6,  4'b0100, 4'b0000, 4'b0000, 4'b0100);
        push_ev(k + 16, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        tick(36);
        chk("ch2_held_state", switch_state, 4'b0100);
        k = cyc; switch_in[2] = 1'b1;
        push_ev(k + 6, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        drain();
        // Re-press: hold timer must have restarted from 0.
        k = cyc; switch_in[2] = 1'b0;
        push_ev(k + 6,  4'b0100, 4'b0000, 4'b0000, 4'b0100);
        push_ev(k + 16, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        tick(20);
        k = cyc; switch_in[2] = 1'b1;
        push_ev(k + 6, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        drain();

        // Channels 0 and 3 together; any_active trails switch_state by one.
        k = cyc; switch_in = 4'b0110;
        push_ev(k + 6,  4'b1001, 4'b0000, 4'b0000, 4'b1001);
        push_ev(k + 16, 4'b0000, 4'b0000, 4'b1001, 4'b1001);
        tick(6);
        chk("dual_any_lag", {3'b0, any_active}, 4'b0000);
        tick(1);
        chk("dual_any_set", {3'b0, any_active}, 4'b0001);
        tick(13);
        k = cyc; switch_in = 4'b1111;
        push_ev(k + 6, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
        drain();
        chk("dual_any_clear", {3'b0, any_active}, 4'b0000);

        // Reset while channel 1 is mid-count (cnt=2), input kept low.
        k = cyc; switch_in[1] = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(3);
        chk("midreset_state", switch_state, 4'b0000);
        reset = 1'b0;
        k = cyc;
        push_ev(k + 6,  4'b0010, 4'b0000, 4'b0000, 4'b0010);
        push_ev(k + 16, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
        tick(20);
        k = cyc; switch_in[1] = 1'b1;
        push_ev(k + 6, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        drain();

        // Chatter on channel 3 every 2 cycles for 50 cycles, ending low.
        for (int i = 0; i < 25; i++) begin
            switch_in[3] = (i % 2 == 0) ? 1'b0 : 1'b1;
            if (i == 24) begin
                k = cyc;
                push_ev(k + 6,  4'b1000, 4'b0000, 4'b0000, 4'b1000);
                push_ev(k + 16, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
            end else begin
                chk("chatter_state", switch_state, 4'b0000);
            end
            tick(2);
        end
        tick(18);
        k = cyc; switch_in[3] = 1'b1;
        push_ev(k + 6, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
        drain();
        chk("final_state", switch_state, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
